// File: rtl/fpu_sched.sv
// fpu_sched: in-order issue scheduler for the shared FPU.
// Holds FPU ops in a small circular queue and issues the head either to the
// pipelined FP pipe or to the non-pipelined divider. A reservation shift
// register gives the single writeback slot to at most one result per cycle.
// On a redirect, ops younger than the redirect are squashed.

package fpu_sched_pkg;
    // Redirect bundle: opid[15] marks a valid redirect; topid is the oldest in-flight opid.
    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;
endpackage

module fpu_sched
    import fpu_sched_pkg::*;
#(
    parameter int opsz = 32,
    parameter int qsz  = 4,
    parameter int plat = 4,
    parameter int dlat = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  red_bundle_t redir,
    input  logic        in_valid,
    input  logic [15:0] in_opid,
    input  logic        in_div,
    output logic        in_ready,
    output logic        pipe_issue,
    output logic        div_issue,
    output logic [15:0] issue_opid,
    output logic        wb_valid,
    output logic [15:0] wb_opid
);
    localparam int ow = $clog2(opsz);
    localparam int pw = $clog2(qsz);
    localparam int cw = pw + 1;
    localparam int dw = $clog2(dlat);

    // Age is measured from topid so that opid wraparound inside the ID
    // space does not break the comparison. An op is younger than the
    // redirect when its distance from topid is strictly larger.
    function automatic logic succeed(input logic [15:0] x, input red_bundle_t r);
        logic [ow-1:0] dx;
        logic [ow-1:0] dr;
        dx = x[ow-1:0] - r.topid[ow-1:0];
        dr = r.opid[ow-1:0] - r.topid[ow-1:0];
        return r.opid[15] & x[15] & ({1'b0, dx} >= ({1'b0, dr} + (ow+1)'(1)));
    endfunction

    // Queue state
    logic [15:0]   q_opid [qsz];
    logic          q_div  [qsz];
    logic [pw-1:0] head;
    logic [pw-1:0] tail;
    logic [cw-1:0] count;

    // Writeback reservation and divider occupancy
    logic [dlat:1] rsv;
    logic [15:0]   tag [1:dlat];
    logic [dw-1:0] dcnt;

    // Next-state helpers
    logic [15:0]   head_opid;
    logic          head_div;
    logic          head_ok;
    logic          issue;
    logic          enq;
    logic          squash;
    logic [cw-1:0] keep;
    logic [cw-1:0] count_nx;
    logic [pw-1:0] wr_ptr;
    logic [dlat:1] rsv_sh;
    logic [dlat:1] rsv_nx;
    logic [15:0]   tag_nx [1:dlat];

    // Only the low ow bits of the redirect opids take part in age arithmetic.
    logic unused_redir_bits;
    assign unused_redir_bits = ^{redir.opid[14:ow], redir.topid[15:ow]};

    // Find the first younger entry from the head; everything before it survives.
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        keep   = count;
        squash = 1'b0;
        for (int i = 0; i < qsz; i++) begin
            if (!squash && (cw'(i) < count) && succeed(q_opid[head + pw'(i)], redir)) begin
                keep   = cw'(i);
                squash = 1'b1;
            end
        end
    end

    // The head can issue only if it is valid and not itself being squashed.
    // rsv_sh is the reservation vector as it will look after this cycle's shift.
    assign head_opid  = q_opid[head];
    assign head_div   = q_div[head];
    assign rsv_sh     = {1'b0, rsv[dlat:2]};
    assign head_ok    = (count != '0) && !succeed(head_opid, redir);
    assign pipe_issue = head_ok && !head_div && !rsv_sh[plat];
    assign div_issue  = head_ok &&  head_div && (dcnt == '0) && !rsv_sh[dlat];
    assign issue      = pipe_issue || div_issue;
    assign issue_opid = issue ? head_opid : '0;

    // Enqueue is gated by the registered count only; younger arrivals
    // during a redirect are dropped on the floor.
    assign in_ready = (count < cw'(qsz));
    assign enq      = in_valid && in_ready && !succeed(in_opid, redir);
    assign wr_ptr   = squash ? head + keep[pw-1:0] : tail;
    assign count_nx = keep - cw'(issue) + cw'(enq);

    // Writeback slot is the bottom of the reservation register.
    assign wb_valid = rsv[1] & tag[1][15];
    assign wb_opid  = wb_valid ? tag[1] : '0;

    // Shift reservations and tags, drop squashed tags, then book the issued slot.
    // Squashed results keep their rsv bit so the slot stays owned.
    always_comb begin
        rsv_nx = rsv_sh;
        for (int k = 1; k < dlat; k++) begin
            tag_nx[k] = succeed(tag[k+1], redir) ? 16'h0000 : tag[k+1];
        end
        tag_nx[dlat] = '0;
        if (pipe_issue) begin
            rsv_nx[plat] = 1'b1;
            tag_nx[plat] = head_opid;
        end
        if (div_issue) begin
            rsv_nx[dlat] = 1'b1;
            tag_nx[dlat] = head_opid;
        end
    end

    // Control state: pointers, count, reservations, tags and divider busy counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rsv   <= '0;
            dcnt  <= '0;
            for (int k = 1; k <= dlat; k++) begin
                tag[k] <= '0;
            end
        end else begin
            head  <= head + pw'(issue);
            tail  <= wr_ptr + pw'(enq);
            count <= count_nx;
            rsv   <= rsv_nx;
            for (int k = 1; k <= dlat; k++) begin
                tag[k] <= tag_nx[k];
            end
            if (div_issue) begin
                dcnt <= dw'(dlat - 1);
            end else if (dcnt != '0) begin
                dcnt <= dcnt - dw'(1);
            end
        end
    end

    // Queue payload write at the (possibly pulled-back) tail.
    // NOTE: queue storage is not reset; an entry is only read while count
    // covers it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_opid[wr_ptr] <= in_opid;
            q_div[wr_ptr]  <= in_div;
        end
    end

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed scenarios with hand-computed cycle expectations.
// Each scenario starts from reset; cycle 0 is the first cycle after release.
// Outputs of every cycle are logged 1ns after inputs settle and checked afterwards.

module tb_fpu_sched;
    import fpu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    red_bundle_t redir;
    logic        in_valid;
    logic [15:0] in_opid;
    logic        in_div;
    logic        in_ready;
    logic        pipe_issue;
    logic        div_issue;
    logic [15:0] issue_opid;
    logic        wb_valid;
    logic [15:0] wb_opid;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic        l_rdy  [128];
    logic        l_pi   [128];
    logic        l_di   [128];
    logic        l_wbv  [128];
    logic [15:0] l_iop  [128];
    logic [15:0] l_wbop [128];

    always #5 clk = ~clk;

    fpu_sched #(.opsz(32), .qsz(4), .plat(4), .dlat(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .redir      (redir),
        .in_valid   (in_valid),
        .in_opid    (in_opid),
        .in_div     (in_div),
        .in_ready   (in_ready),
        .pipe_issue (pipe_issue),
        .div_issue  (div_issue),
        .issue_opid (issue_opid),
        .wb_valid   (wb_valid),
        .wb_opid    (wb_opid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] opn(input int i);
        return 16'h8000 | 16'(i);
    endfunction

    task automatic drive(input logic v, input logic [15:0] op, input logic d,
                         input logic [15:0] r_op, input logic [15:0] r_top);
        in_valid    = v;
        in_opid     = op;
        in_div      = d;
        redir.opid  = r_op;
        redir.topid = r_top;
    endtask

    // One cycle: apply inputs, log settled outputs, advance past the edge.
    task automatic run(input logic v, input logic [15:0] op, input logic d,
                       input logic [15:0] r_op, input logic [15:0] r_top);
        drive(v, op, d, r_op, r_top);
        #1;
        l_rdy[cyc]  = in_ready;
        l_pi[cyc]   = pipe_issue;
        l_di[cyc]   = div_issue;
        l_iop[cyc]  = issue_opid;
        l_wbv[cyc]  = wb_valid;
        l_wbop[cyc] = wb_opid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},   32'(in_ready),   32'd1);
        check({tag, ".pipe_issue"}, 32'(pipe_issue), 32'd0);
        check({tag, ".div_issue"},  32'(div_issue),  32'd0);
        check({tag, ".issue_opid"}, 32'(issue_opid), 32'd0);
        check({tag, ".wb_valid"},   32'(wb_valid),   32'd0);
        check({tag, ".wb_opid"},    32'(wb_opid),    32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_issue(input int c, input logic pi, input logic di, input logic [15:0] op);
        check($sformatf("c%0d.pipe_issue", c), 32'(l_pi[c]),  32'(pi));
        check($sformatf("c%0d.div_issue", c),  32'(l_di[c]),  32'(di));
        check($sformatf("c%0d.issue_opid", c), 32'(l_iop[c]), 32'(op));
    endtask

    task automatic check_wb(input int c, input logic [15:0] op);
        check($sformatf("c%0d.wb_valid", c), 32'(l_wbv[c]),  32'(op != 16'h0));
        check($sformatf("c%0d.wb_opid", c),  32'(l_wbop[c]), 32'(op));
    endtask

    function automatic int wb_count(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (l_wbv[c]) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Four back-to-back pipe ops
        do_reset();
        for (int i = 0; i < 4; i++) run(1'b1, opn(i), 1'b0, 16'h0, 16'h0);
        idle(8);
        check_issue(0, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 4; i++) check_issue(i, 1'b1, 1'b0, opn(i - 1));
        check_issue(5, 1'b0, 1'b0, 16'h0);
        check_wb(4, 16'h0);
        for (int i = 5; i <= 8; i++) check_wb(i, opn(i - 5));
        check_wb(9, 16'h0);

        // Two divides: second waits for the divider to drain
        do_reset();
        run(1'b1, opn(0), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(1), 1'b1, 16'h0, 16'h0);
        idle(26);
        check_issue(1, 1'b0, 1'b1, opn(0));
        check_issue(2, 1'b0, 1'b0, 16'h0);
        check_issue(12, 1'b0, 1'b0, 16'h0);
        check_issue(13, 1'b0, 1'b1, opn(1));
        check_wb(12, 16'h0);
        check_wb(13, opn(0));
        check_wb(24, 16'h0);
        check_wb(25, opn(1));

        // Pipe op collides with the divider's writeback slot
        do_reset();
        run(1'b1, opn(0), 1'b1, 16'h0, 16'h0);
        idle(7);
        run(1'b1, opn(1), 1'b0, 16'h0, 16'h0);
        idle(12);
        check_issue(9, 1'b0, 1'b0, 16'h0);
        check_issue(10, 1'b1, 1'b0, opn(1));
        check_wb(13, opn(0));
        check_wb(14, opn(1));
        check("slot.wb_pulses", 32'(wb_count(0, 20)), 32'd2);

        // Full queue behind a busy divider
        do_reset();
        run(1'b1, opn(0), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(1), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(2), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(3), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(4), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(5), 1'b0, 16'h0, 16'h0);
        idle(22);
        check("full.c4.in_ready",  32'(l_rdy[4]),  32'd1);
        check("full.c5.in_ready",  32'(l_rdy[5]),  32'd0);
        check("full.c13.in_ready", 32'(l_rdy[13]), 32'd0);
        check("full.c14.in_ready", 32'(l_rdy[14]), 32'd1);
        check_issue(13, 1'b0, 1'b1, opn(1));
        check_issue(14, 1'b1, 1'b0, opn(2));
        check_issue(16, 1'b1, 1'b0, opn(4));
        check_issue(17, 1'b0, 1'b0, 16'h0);
        check_wb(18, opn(2));
        check_wb(25, opn(1));

        // Redirect: squash queue tail, in-flight younger tag, and same-cycle enqueue
        do_reset();
        run(1'b1, opn(2), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(3), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(5), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(6), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(7), 1'b0, 16'h0, 16'h0);
        run(1'b1, opn(8), 1'b0, opn(4), opn(0));
        idle(8);
        run(1'b1, opn(9), 1'b0, 16'h0, 16'h0);
        idle(7);
        check_issue(2, 1'b1, 1'b0, opn(3));
        check_issue(3, 1'b1, 1'b0, opn(5));
        check_issue(5, 1'b0, 1'b0, 16'h0);
        check_issue(6, 1'b0, 1'b0, 16'h0);
        check_wb(6, opn(3));
        check_wb(7, 16'h0);
        check_issue(13, 1'b0, 1'b0, 16'h0);
        check_wb(13, opn(2));
        check_issue(15, 1'b1, 1'b0, opn(9));
        check_wb(19, opn(9));

        // Reset pulsed in the middle of a divide
        do_reset();
        run(1'b1, opn(0), 1'b1, 16'h0, 16'h0);
        run(1'b1, opn(1), 1'b1, 16'h0, 16'h0);
        idle(3);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        l_wbv[cyc] = wb_valid;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        run(1'b1, opn(16), 1'b1, 16'h0, 16'h0);
        idle(14);
        check_issue(6, 1'b0, 1'b0, 16'h0);
        check_issue(7, 1'b0, 1'b1, opn(16));
        check_wb(13, 16'h0);
        check_wb(19, opn(16));
        check("midrst.wb_pulses", 32'(wb_count(5, 20)), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
